// File: rtl/mix_cols_seq.sv
// rtl/mix_cols_seq.sv - sequential AES MixColumns engine, one column per clock
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   in_state holds a block to mix
//   in_ready   engine is idle and can accept a block
//   in_state   128-bit state; column c = [127-32c -: 32], byte 0 in [31:24]
//   out_valid  out_state holds a mixed block
//   out_ready  downstream accepts out_state
//   out_state  mixed state, same layout as in_state
//   inverse    (MIX_COLS_INV_EN only) select InvMixColumns, latched on accept
//
// Optional feature macro: MIX_COLS_INV_EN

module mix_cols_seq (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
`ifdef MIX_COLS_INV_EN
   ,
   input  logic         inverse
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MIX  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t         fsm_q;
   fsm_t         fsm_d;
   logic [1:0]   col_q;
   logic [127:0] blk_q;
   logic         load;
   logic         mix_en;
   logic [31:0]  col_in;
   logic [31:0]  col_mixed;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_fwd(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] x0, x1, x2, x3;
      a0 = a[31:24];
      a1 = a[23:16];
      a2 = a[15:8];
      a3 = a[7:0];
      x0 = xtime(a0);
      x1 = xtime(a1);
      x2 = xtime(a2);
      x3 = xtime(a3);
      return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
              a0 ^ x1 ^ x2 ^ a2 ^ a3,
              a0 ^ a1 ^ x2 ^ x3 ^ a3,
              x0 ^ a0 ^ a1 ^ a2 ^ x3};
   endfunction

`ifdef MIX_COLS_INV_EN
   logic inv_q;

   // 9x, 11x, 13x, 14x built from the x2/x4/x8 multiples of one byte.
   function automatic logic [31:0] mul_set(input logic [7:0] x);
      logic [7:0] m2, m4, m8;
      m2 = xtime(x);
      m4 = xtime(m2);
      m8 = xtime(m4);
      return {m8 ^ x, m8 ^ m2 ^ x, m8 ^ m4 ^ x, m8 ^ m4 ^ m2};
   endfunction

   // Each mul_set result packs {9x, 11x, 13x, 14x}.
   function automatic logic [31:0] mix_inv(input logic [31:0] a);
      logic [31:0] p0, p1, p2, p3;
      p0 = mul_set(a[31:24]);
      p1 = mul_set(a[23:16]);
      p2 = mul_set(a[15:8]);
      p3 = mul_set(a[7:0]);
      return {p0[7:0]   ^ p1[23:16] ^ p2[15:8]  ^ p3[31:24],
              p0[31:24] ^ p1[7:0]   ^ p2[23:16] ^ p3[15:8],
              p0[15:8]  ^ p1[31:24] ^ p2[7:0]   ^ p3[23:16],
              p0[23:16] ^ p1[15:8]  ^ p2[31:24] ^ p3[7:0]};
   endfunction
`endif

   // Handshake outputs decode the registered state only, so out_ready never
   // reaches in_ready combinationally.
   always_comb begin
      fsm_d     = fsm_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      mix_en    = 1'b0;
      case (fsm_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load  = 1'b1;
               fsm_d = MIX;
            end
         end
         MIX: begin
            mix_en = 1'b1;
            if (col_q == 2'd3) begin
               fsm_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_comb begin
      col_in = 32'h0;
      case (col_q)
         2'd0: col_in = blk_q[127:96];
         2'd1: col_in = blk_q[95:64];
         2'd2: col_in = blk_q[63:32];
         2'd3: col_in = blk_q[31:0];
         default: col_in = 32'h0;
      endcase
   end

`ifdef MIX_COLS_INV_EN
   assign col_mixed = inv_q ? mix_inv(col_in) : mix_fwd(col_in);
`else
   assign col_mixed = mix_fwd(col_in);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q <= IDLE;
         col_q <= 2'd0;
         blk_q <= 128'h0;
`ifdef MIX_COLS_INV_EN
         inv_q <= 1'b0;
`endif
      end else begin
         fsm_q <= fsm_d;
         if (load) begin
            blk_q <= in_state;
            col_q <= 2'd0;
`ifdef MIX_COLS_INV_EN
            inv_q <= inverse;
`endif
         end else if (mix_en) begin
            case (col_q)
               2'd0: blk_q[127:96] <= col_mixed;
               2'd1: blk_q[95:64]  <= col_mixed;
               2'd2: blk_q[63:32]  <= col_mixed;
               2'd3: blk_q[31:0]   <= col_mixed;
               default: blk_q <= blk_q;
            endcase
            // Wraps 3 -> 0 on the final column, leaving col at 0 in DONE.
            col_q <= col_q + 2'd1;
         end
      end
   end

   // The working register doubles as the output; meaningful only in DONE.
   assign out_state = blk_q;

endmodule

// File: tb/tb_mix_cols_seq.sv
// tb/tb_mix_cols_seq.sv - directed self-checking bench for mix_cols_seq

module tb_mix_cols_seq;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
`ifdef MIX_COLS_INV_EN
   logic         inverse;
`endif

   int n_vec;
   int n_err;
   int lat;

   localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
   localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
   localparam logic [127:0] COL_IN   = 128'hc9dad76a_5c220af2_01010101_c6c6c6c6;
   localparam logic [127:0] COL_OUT  = 128'h416e1899_26f46733_01010101_c6c6c6c6;
   localparam logic [127:0] WIKI_IN  = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
   localparam logic [127:0] WIKI_OUT = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;

   mix_cols_seq dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state)
`ifdef MIX_COLS_INV_EN
      ,
      .inverse   (inverse)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a block in IDLE, take the accept edge, then drop in_valid.
   task automatic send(input string tag, input logic [127:0] s);
      in_state = s;
      in_valid = 1'b1;
      chk({tag, "_ready_before"}, {127'h0, in_ready}, 128'h1);
      tick();
      in_valid = 1'b0;
      chk({tag, "_ready_after"}, {127'h0, in_ready}, 128'h0);
   endtask

   // Edges from accept until out_valid, bounded so a stuck engine still ends.
   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      if (!out_valid) n = 99;
   endtask

   task automatic run_block(input string tag, input logic [127:0] s, input logic [127:0] exp);
      out_ready = 1'b1;
      send(tag, s);
      wait_done(lat);
      chk({tag, "_latency"}, 128'(lat), 128'd4);
      chk({tag, "_state"}, out_state, exp);
      chk({tag, "_ready_in_done"}, {127'h0, in_ready}, 128'h0);
      tick();
      chk({tag, "_valid_after_hs"}, {127'h0, out_valid}, 128'h0);
      chk({tag, "_ready_after_hs"}, {127'h0, in_ready}, 128'h1);
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_state  = FIPS_IN;
      out_ready = 1'b0;
`ifdef MIX_COLS_INV_EN
      inverse   = 1'b0;
`endif
      // Reset wins over a pending in_valid.
      tick();
      tick();
      in_valid = 1'b0;
      reset    = 1'b0;
      chk("reset_in_ready", {127'h0, in_ready}, 128'h1);
      chk("reset_out_valid", {127'h0, out_valid}, 128'h0);
      chk("reset_out_state", out_state, 128'h0);
      tick();
      chk("idle_in_ready", {127'h0, in_ready}, 128'h1);
      chk("idle_out_valid", {127'h0, out_valid}, 128'h0);

      run_block("fips", FIPS_IN, FIPS_OUT);
      run_block("cols", COL_IN, COL_OUT);

      // Backpressure with a second block waiting on in_valid.
      out_ready = 1'b0;
      send("bp", WIKI_IN);
      wait_done(lat);
      chk("bp_latency", 128'(lat), 128'd4);
      in_state = FIPS_IN;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold_state", out_state, WIKI_OUT);
         chk("bp_hold_valid", {127'h0, out_valid}, 128'h1);
         chk("bp_hold_ready", {127'h0, in_ready}, 128'h0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_hs_valid", {127'h0, out_valid}, 128'h0);
      chk("bp_hs_ready", {127'h0, in_ready}, 128'h1);
      tick();
      in_valid = 1'b0;
      chk("bp_second_accepted", {127'h0, in_ready}, 128'h0);
      wait_done(lat);
      chk("bp_second_latency", 128'(lat), 128'd4);
      chk("bp_second_state", out_state, FIPS_OUT);
      tick();
      chk("bp_second_done", {127'h0, out_valid}, 128'h0);

      // Reset while mixing column 2 discards the block.
      out_ready = 1'b1;
      send("rst", COL_IN);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
      chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
      chk("rst_out_state", out_state, 128'h0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rst_no_valid", {127'h0, out_valid}, 128'h0);
      end
      run_block("after_rst", WIKI_IN, WIKI_OUT);

`ifdef MIX_COLS_INV_EN
      inverse = 1'b1;
      run_block("inv", COL_OUT, COL_IN);
      inverse = 1'b0;
      run_block("fwd_again", FIPS_IN, FIPS_OUT);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
